// File: rtl/gan_q15_pkg.sv
// Shared constants and FSM encoding for the Q1.15 GAN pixel path.
// Default geometry is a 3x3 frame of 16-bit pixels.
package gan_q15_pkg;

    localparam int PIX_W_DEF = 16;
    localparam int NPIX_DEF  = 9;
    localparam int FCNT_W    = 16;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } asm_state_e;

endpackage

// File: rtl/pixel_assembler_q15.sv
// Serial Q1.15 pixels -> parallel 3x3 frame; out_valid rises 1 cycle after the last beat; registered in_ready backpressures upstream.
// PIXEL_ASSEMBLER_DBUF_EN adds a fill buffer so the next frame fills while one is held on image_*.
module pixel_assembler_q15
    import gan_q15_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int NPIX  = NPIX_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [PIX_W-1:0] in_pixel,
    input  logic                    in_last,
    output logic signed [PIX_W-1:0] image_0,
    output logic signed [PIX_W-1:0] image_1,
    output logic signed [PIX_W-1:0] image_2,
    output logic signed [PIX_W-1:0] image_3,
    output logic signed [PIX_W-1:0] image_4,
    output logic signed [PIX_W-1:0] image_5,
    output logic signed [PIX_W-1:0] image_6,
    output logic signed [PIX_W-1:0] image_7,
    output logic signed [PIX_W-1:0] image_8,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    frame_err,
    output logic [FCNT_W-1:0]       frame_cnt
);

    localparam int IDX_W = $clog2(NPIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    typedef logic signed [PIX_W-1:0] pix_t;

    pix_t              img_q [NPIX];
    pix_t              img_d [NPIX];
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              in_ready_q, in_ready_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic beat, at_last, frame_done, frame_bad, pop;

`ifdef PIXEL_ASSEMBLER_DBUF_EN
    pix_t       fill_q [NPIX];
    pix_t       fill_d [NPIX];
    asm_state_e state_q, state_d;
    logic       slot_free;
`endif

    always_comb begin
        beat       = in_valid && in_ready_q;
        at_last    = (wr_idx_q == LAST_IDX);
        frame_done = beat && at_last && in_last;
        // A last flag off the final slot, or a missing one on it, both break framing.
        frame_bad  = beat && (at_last != in_last);
        pop        = out_valid_q && out_ready;

        img_d       = img_q;
        wr_idx_d    = wr_idx_q;
        out_valid_d = out_valid_q && !pop;
        frame_err_d = frame_bad;
        frame_cnt_d = frame_cnt_q + FCNT_W'(pop);

        if (beat) begin
            wr_idx_d = (frame_done || frame_bad) ? '0 : wr_idx_q + IDX_W'(1);
        end

`ifdef PIXEL_ASSEMBLER_DBUF_EN
        fill_d    = fill_q;
        state_d   = state_q;
        slot_free = !out_valid_q || out_ready;
        if (beat) begin
            fill_d[wr_idx_q] = in_pixel;
        end
        case (state_q)
            ST_FILL: begin
                if (frame_done) begin
                    if (slot_free) begin
                        img_d       = fill_d;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (slot_free) begin
                    img_d       = fill_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
`else
        if (beat) begin
            img_d[wr_idx_q] = in_pixel;
        end
        if (frame_done) begin
            out_valid_d = 1'b1;
        end
`endif

        // Flush wins over any same-cycle beat or handshake; images and count are kept.
        if (flush) begin
            img_d       = img_q;
            wr_idx_d    = '0;
            out_valid_d = 1'b0;
            frame_err_d = 1'b0;
            frame_cnt_d = frame_cnt_q;
`ifdef PIXEL_ASSEMBLER_DBUF_EN
            fill_d  = fill_q;
            state_d = ST_FILL;
`endif
        end

`ifdef PIXEL_ASSEMBLER_DBUF_EN
        in_ready_d = (state_d == ST_FILL);
`else
        in_ready_d = !out_valid_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) begin
                img_q[i] <= '0;
            end
            wr_idx_q    <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            in_ready_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            img_q       <= img_d;
            wr_idx_q    <= wr_idx_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            in_ready_q  <= in_ready_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef PIXEL_ASSEMBLER_DBUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) begin
                fill_q[i] <= '0;
            end
            state_q <= ST_FILL;
        end else begin
            fill_q  <= fill_d;
            state_q <= state_d;
        end
    end
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
    assign image_0   = img_q[0];
    assign image_1   = img_q[1];
    assign image_2   = img_q[2];
    assign image_3   = img_q[3];
    assign image_4   = img_q[4];
    assign image_5   = img_q[5];
    assign image_6   = img_q[6];
    assign image_7   = img_q[7];
    assign image_8   = img_q[8];

endmodule

// File: doc/pixel_assembler_q15.md
PIXEL_ASSEMBLER_Q15 -- requirements
Module: pixel_assembler_q15

Interface
REQ-001 SHALL have parameter PIX_W, default 16, pixel width (Q1.15, signed).
REQ-002 SHALL have parameter NPIX, default 9, pixels per frame (3x3 image).
REQ-003 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous clear of all frame state.
REQ-006 SHALL have port in_valid, input, 1, upstream pixel valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts a pixel this cycle.
REQ-008 SHALL have port in_pixel, input, PIX_W signed, raster-order pixel (index 0 first).
REQ-009 SHALL have port in_last, input, 1, marks the final pixel of a frame.
REQ-010 SHALL have ports image_0..image_8, output, PIX_W signed each, parallel frame to the discriminator.
REQ-011 SHALL have port out_valid, output, 1, image_* holds a complete frame.
REQ-012 SHALL have port out_ready, input, 1, downstream consumes the frame.
REQ-013 SHALL have port frame_err, output, 1, one-cycle pulse on framing error.
REQ-014 SHALL have port frame_cnt, output, 16, count of delivered frames.

Function
REQ-015 SHALL accept a beat when in_valid && in_ready; store in_pixel at fill index wr_idx (0..NPIX-1), then increment wr_idx.
REQ-016 SHALL complete a frame when the beat at wr_idx==NPIX-1 carries in_last=1; wr_idx returns to 0.
REQ-017 SHALL treat in_last=1 at wr_idx<NPIX-1, or in_last=0 at wr_idx==NPIX-1, as an error: discard the partial frame, set wr_idx=0, pulse frame_err for exactly one cycle on the next cycle.
REQ-018 SHALL use FSM states FILL (accepting, in_ready=1) and PEND (complete frame waiting for output slot, in_ready=0).
REQ-019 SHALL move a completed frame to the output registers in the cycle after completion when out_valid=0 or out_ready=1 (FILL stays); otherwise enter PEND.
REQ-020 SHALL, in PEND, transfer to output when out_valid=0 or out_ready=1, then return to FILL next cycle.
REQ-021 SHALL assert out_valid the cycle after the completing beat when the slot is free (latency 1 cycle from 9th beat).
REQ-022 SHALL deassert out_valid after out_valid && out_ready unless a new frame transfers the same cycle.
REQ-023 SHALL keep image_* stable while out_valid && !out_ready.
REQ-024 SHALL increment frame_cnt on each out_valid && out_ready, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL, on flush=1, clear wr_idx, PEND, out_valid, frame_err next cycle; flush overrides a same-cycle beat or handshake; frame_cnt and image_* retained.
REQ-026 SHALL pass pixel values unmodified (no rounding or saturation).

Reset
REQ-027 SHALL on rst_n=0 immediately force: state FILL, wr_idx=0, out_valid=0, frame_err=0, frame_cnt=0, image_*=0, fill buffer=0.
REQ-028 SHALL hold in_ready=0 while rst_n=0; in_ready=1 from the first clock after deassertion; a mid-frame reset discards the partial frame.

Configuration
REQ-029 SHALL use macro PIXEL_ASSEMBLER_DBUF_EN.
REQ-030 SHALL, with PIXEL_ASSEMBLER_DBUF_EN defined, keep separate fill and output buffers (REQ-018..020).
REQ-031 SHALL, without it, use a single buffer driving image_*: in_ready=0 while out_valid=1, PEND unused, image_* updates beat by beat while out_valid=0.

Structure
REQ-032 SHALL place PIX_W, NPIX, FSM state encoding and frame_cnt width in shared package gan_q15_pkg.
REQ-033 SHALL be implemented flat; no sub-module.

Verification
REQ-034 SHALL cover: pixels 0x0001..0x0009, last on 9th, out_ready=1 -> out_valid 1 cycle after 9th beat, image_0=0x0001..image_8=0x0009, frame_cnt=1.
REQ-035 SHALL cover (DBUF on): two back-to-back frames, out_ready=0 -> second frame enters PEND, in_ready=0; out_ready=1 one cycle -> frame 2 on image_*, in_ready=1 next cycle.
REQ-036 SHALL cover: in_last on 5th beat -> frame_err pulse 1 cycle, out_valid stays 0, next 9-beat frame delivered correctly.
REQ-037 SHALL cover: rst_n=0 after 4 beats -> all outputs 0 asynchronously; fresh frame after release delivered intact.
REQ-038 SHALL cover: flush with a beat on the same cycle -> beat dropped, wr_idx=0, out_valid=0.
REQ-039 SHALL cover: frame_cnt preloaded via 65535 handshakes -> one more handshake gives frame_cnt=0x0000.
